// File: rtl/anc_lms_mc.sv
// anc_lms_mc: multi-channel adaptive ANC engine, per-channel FIR + LMS on one shared MAC.
// Ports: clk, rst_n, in_valid/in_ready/x_in/e_in/mu_in/adapt_en in; out_sample/out_valid/out_ready/sat_seen out. Option: ANC_LEAK_EN.
module anc_lms_mc #(
  parameter int DW         = 16,
  parameter int TAPS       = 32,
  parameter int CH         = 2,
  parameter int ACCW       = 40,
  parameter int FRAC       = 15,
  parameter int LEAK_SHIFT = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] x_in,
  input  logic [CH*DW-1:0] e_in,
  input  logic [DW-1:0]    mu_in,
  input  logic             adapt_en,
  output logic [CH*DW-1:0] out_sample,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat_seen
);

  localparam int KW = $clog2(TAPS);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW = 2 * DW;
  localparam int SW = ((ACCW > PW) ? ACCW : PW) + 2;

  localparam logic signed [SW-1:0] MAXV =
    {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV =
    {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [SW-1:0] HALF =
    {{(SW-1){1'b0}}, 1'b1} << (FRAC-1);

  if (TAPS < 2 || CH < 1 || LEAK_SHIFT < 0 ||
      ACCW < 2*DW + $clog2(TAPS)) begin : g_bad_cfg
    $error("anc_lms_mc: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_UPD, S_SHIFT, S_FIR, S_DONE, S_OUT
  } state_t;

  state_t state;

  logic signed [DW-1:0]   w    [CH][TAPS];
  logic signed [DW-1:0]   d    [CH][TAPS];
  logic signed [DW-1:0]   x_r  [CH];
  logic signed [DW-1:0]   e_r  [CH];
  logic signed [DW-1:0]   y_r  [CH];
  logic signed [DW-1:0]   mu_r;
  logic [CW-1:0]          c_idx;
  logic [KW-1:0]          k_idx;
  logic signed [ACCW-1:0] acc;

  function automatic logic signed [SW-1:0] sx_d(
    input logic signed [DW-1:0] v);
    return {{(SW-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic signed [SW-1:0] sx_p(
    input logic signed [PW-1:0] v);
    return {{(SW-PW){v[PW-1]}}, v};
  endfunction

  function automatic logic signed [SW-1:0] sx_a(
    input logic signed [ACCW-1:0] v);
    return {{(SW-ACCW){v[ACCW-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] ext_p(
    input logic signed [DW-1:0] v);
    return {{DW{v[DW-1]}}, v};
  endfunction

  function automatic logic clip(input logic signed [SW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [DW-1:0] sat_dw(
    input logic signed [SW-1:0] v);
    if (v > MAXV) return MAXV[DW-1:0];
    if (v < MINV) return MINV[DW-1:0];
    return v[DW-1:0];
  endfunction

  // shared datapath, one (channel, tap) per cycle
  logic signed [DW-1:0]   x_sel, w_sel, e_sel, g, w_new, y_new;
  logic signed [PW-1:0]   ge_p, gx_p, prod;
  logic signed [SW-1:0]   ge_s, delta, upd_sum, rnd;
  logic signed [ACCW-1:0] acc_next;
  logic                   g_clip, w_clip, y_clip;
  logic                   last_k, last_c;

  assign x_sel = d[c_idx][k_idx];
  assign w_sel = w[c_idx][k_idx];
  assign e_sel = e_r[c_idx];

  assign ge_p   = ext_p(mu_r) * ext_p(e_sel);
  assign ge_s   = sx_p(ge_p) >>> FRAC;
  assign g      = sat_dw(ge_s);
  assign g_clip = clip(ge_s);

  assign gx_p  = ext_p(g) * ext_p(x_sel);
  assign delta = sx_p(gx_p) >>> FRAC;

`ifdef ANC_LEAK_EN
  assign upd_sum = sx_d(w_sel) - (sx_d(w_sel) >>> LEAK_SHIFT)
                 + delta;
`else
  assign upd_sum = sx_d(w_sel) + delta;
`endif

  assign w_new  = sat_dw(upd_sum);
  assign w_clip = clip(upd_sum);

  assign prod     = ext_p(w_sel) * ext_p(x_sel);
  assign acc_next = acc + {{(ACCW-PW){prod[PW-1]}}, prod};
  // round half up before dropping the fraction
  assign rnd      = (sx_a(acc_next) + HALF) >>> FRAC;
  assign y_new    = sat_dw(rnd);
  assign y_clip   = clip(rnd);

  assign last_k = (k_idx == KW'(TAPS-1));
  assign last_c = (c_idx == CW'(CH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_sample <= '0;
      sat_seen   <= 1'b0;
      mu_r       <= '0;
      c_idx      <= '0;
      k_idx      <= '0;
      acc        <= '0;
      for (int c = 0; c < CH; c++) begin
        x_r[c] <= '0;
        e_r[c] <= '0;
        y_r[c] <= '0;
        for (int k = 0; k < TAPS; k++) begin
          w[c][k] <= '0;
          d[c][k] <= '0;
        end
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            for (int c = 0; c < CH; c++) begin
              x_r[c] <= x_in[c*DW +: DW];
              e_r[c] <= e_in[c*DW +: DW];
            end
            mu_r     <= mu_in;
            sat_seen <= 1'b0;
            in_ready <= 1'b0;
            c_idx    <= '0;
            k_idx    <= '0;
            state    <= adapt_en ? S_UPD : S_SHIFT;
          end
        end
        S_UPD: begin
          w[c_idx][k_idx] <= w_new;
          if (g_clip || w_clip) sat_seen <= 1'b1;
          if (last_k) begin
            k_idx <= '0;
            c_idx <= last_c ? '0 : c_idx + 1'b1;
            if (last_c) state <= S_SHIFT;
          end else begin
            k_idx <= k_idx + 1'b1;
          end
        end
        S_SHIFT: begin
          for (int c = 0; c < CH; c++) begin
            d[c][0] <= x_r[c];
            for (int k = 1; k < TAPS; k++)
              d[c][k] <= d[c][k-1];
          end
          acc   <= '0;
          c_idx <= '0;
          k_idx <= '0;
          state <= S_FIR;
        end
        S_FIR: begin
          if (last_k) begin
            y_r[c_idx] <= y_new;
            if (y_clip) sat_seen <= 1'b1;
            acc   <= '0;
            k_idx <= '0;
            c_idx <= last_c ? '0 : c_idx + 1'b1;
            if (last_c) state <= S_DONE;
          end else begin
            acc   <= acc_next;
            k_idx <= k_idx + 1'b1;
          end
        end
        S_DONE: begin
          for (int c = 0; c < CH; c++)
            out_sample[c*DW +: DW] <= y_r[c];
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_anc_lms_mc.sv
// tb_anc_lms_mc: table vectors, corner sequences and random frames for anc_lms_mc
// against an arithmetic reference model of the LMS/FIR frame rules.
module tb_anc_lms_mc;

  localparam int DW   = 16;
  localparam int TAPS = 32;
  localparam int CH   = 2;
  localparam int LS   = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CH*DW-1:0] x_in = '0;
  logic [CH*DW-1:0] e_in = '0;
  logic [DW-1:0]    mu_in = '0;
  logic             adapt_en = 1'b0;
  logic [CH*DW-1:0] out_sample;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             sat_seen;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  anc_lms_mc #(
    .DW(DW), .TAPS(TAPS), .CH(CH), .ACCW(40),
    .FRAC(15), .LEAK_SHIFT(LS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .e_in(e_in), .mu_in(mu_in),
    .adapt_en(adapt_en),
    .out_sample(out_sample), .out_valid(out_valid),
    .out_ready(out_ready), .sat_seen(sat_seen)
  );

  task automatic chk(input string n, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // reference model: weights and delay lines as plain integers
  int mw [CH][TAPS];
  int md [CH][TAPS];

  task automatic model_reset();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TAPS; k++) begin
        mw[c][k] = 0;
        md[c][k] = 0;
      end
  endtask

  function automatic longint sat_m(input longint v, inout bit s);
    if (v > 32767) begin s = 1; return 32767; end
    if (v < -32768) begin s = 1; return -32768; end
    return v;
  endfunction

  task automatic model_frame(input int x0, input int x1,
                             input int e0, input int e1,
                             input int mu, input bit ad,
                             output int y0, output int y1,
                             output bit s);
    int xs [CH];
    int es [CH];
    int ys [CH];
    longint g, dl, nw, acc;
    s = 0;
    xs[0] = x0; xs[1] = x1;
    es[0] = e0; es[1] = e1;
    if (ad) begin
      for (int c = 0; c < CH; c++) begin
        g = sat_m((longint'(mu) * es[c]) >>> 15, s);
        for (int k = 0; k < TAPS; k++) begin
          dl = (g * longint'(md[c][k])) >>> 15;
`ifdef ANC_LEAK_EN
          nw = longint'(mw[c][k])
             - (longint'(mw[c][k]) >>> LS) + dl;
`else
          nw = longint'(mw[c][k]) + dl;
`endif
          mw[c][k] = int'(sat_m(nw, s));
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      for (int k = TAPS-1; k > 0; k--) md[c][k] = md[c][k-1];
      md[c][0] = xs[c];
    end
    for (int c = 0; c < CH; c++) begin
      acc = 0;
      for (int k = 0; k < TAPS; k++)
        acc += longint'(mw[c][k]) * md[c][k];
      ys[c] = int'(sat_m((acc + 16384) >>> 15, s));
    end
    y0 = ys[0];
    y1 = ys[1];
  endtask

  function automatic int sx16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // one complete frame: accept, latency, model compare, optional stall, drain
  task automatic frame(input int x0, input int x1,
                       input int e0, input int e1,
                       input int mu, input bit ad,
                       input int hold, input string tag,
                       output int y0, output int y1,
                       output bit s);
    int lat;
    int ey0, ey1;
    bit es;
    logic [CH*DW-1:0] snap;
    @(negedge clk);
    chk({tag, ".in_ready"}, in_ready, 1);
    x_in     = {x1[15:0], x0[15:0]};
    e_in     = {e1[15:0], e0[15:0]};
    mu_in    = mu[15:0];
    adapt_en = ad;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_frame(x0, x1, e0, e1, mu, ad, ey0, ey1, es);
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk({tag, ".latency"}, lat, ad ? 130 : 66);
    y0 = sx16(out_sample[15:0]);
    y1 = sx16(out_sample[31:16]);
    s  = sat_seen;
    chk({tag, ".y0"}, y0, ey0);
    chk({tag, ".y1"}, y1, ey1);
    chk({tag, ".sat"}, s, es);
    snap = out_sample;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x_in     = {$urandom, $urandom};
      e_in     = {$urandom, $urandom};
      adapt_en = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, ".stall"},
          (out_sample == snap) && out_valid && !in_ready, 1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, ".idle_rdy"}, in_ready, 1);
    chk({tag, ".idle_ov"}, out_valid, 0);
  endtask

  typedef struct {
    int x0; int e0; int mu; bit ad;
    int y0; int y1; int hold;
  } vec_t;

  initial begin
    vec_t tbl [3];
    int   y0, y1;
    bit   s;

    tbl[0] = '{x0:'h4000, e0:0,      mu:'h4000, ad:1,
               y0:0,      y1:0, hold:0};
    tbl[1] = '{x0:0,      e0:'h4000, mu:'h4000, ad:1,
               y0:0,      y1:0, hold:0};
    tbl[2] = '{x0:'h4000, e0:0,      mu:'h4000, ad:1,
               y0:'h0800, y1:0, hold:20};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_sample", out_sample, 0);
    chk("rst.sat_seen", sat_seen, 0);
    @(negedge clk) rst_n = 1'b1;

    // LMS step: A, B (w0 becomes 0x1000), C with a stalled output
    for (int i = 0; i < 3; i++) begin
      frame(tbl[i].x0, 0, tbl[i].e0, 0, tbl[i].mu, tbl[i].ad,
            tbl[i].hold, $sformatf("lms%0d", i), y0, y1, s);
      chk($sformatf("lms%0d.tbl_y0", i), y0, tbl[i].y0);
      chk($sformatf("lms%0d.tbl_y1", i), y1, tbl[i].y1);
    end

    // reset in the middle of FIR clears weights and delay lines
    @(negedge clk);
    x_in     = {16'h0, 16'h1234};
    e_in     = '0;
    adapt_en = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("mid.in_ready", in_ready, 1);
    chk("mid.out_valid", out_valid, 0);
    chk("mid.out_sample", out_sample, 0);
    chk("mid.sat_seen", sat_seen, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    frame('h4000, 0, 0, 0, 'h4000, 0, 0, "post_rst", y0, y1, s);
    chk("post_rst.zero", y0, 0);

    // saturation on ch1 only
    for (int i = 0; i < 5; i++)
      frame(0, 'h7FFF, 0, 'h7FFF, 'h7FFF, 1, 0,
            $sformatf("sat%0d", i), y0, y1, s);
    chk("sat.y1_clamp", y1, 32767);
    chk("sat.flag", s, 1);
    chk("sat.y0_quiet", y0, 0);

    // random frames against the model
    for (int i = 0; i < 16; i++) begin
      int rx0, rx1, re0, re1, rmu;
      rx0 = sx16(16'($urandom));
      rx1 = sx16(16'($urandom));
      re0 = sx16(16'($urandom));
      re1 = sx16(16'($urandom));
      rmu = (i < 8) ? int'($urandom_range(0, 'h0FFF))
                    : sx16(16'($urandom));
      frame(rx0, rx1, re0, re1, rmu, 1'($urandom), 0,
            $sformatf("rnd%0d", i), y0, y1, s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
